// File: rtl/glyph_layer_gen_if.sv
// Pixel-side bundle for glyph_layer_gen: raster position, per-layer configuration and composited output.
interface glyph_layer_gen_if #(
    parameter int GLYPH_W    = 8,
    parameter int GLYPH_H    = 8,
    parameter int NUM_LAYERS = 2
);
    localparam int G = GLYPH_W * GLYPH_H;

    logic                        pix_en;
    logic                        bright;
    logic [9:0]                  hcount;
    logic [9:0]                  vcount;
    logic [NUM_LAYERS-1:0]       layer_en;
    logic [10*NUM_LAYERS-1:0]    x_start;
    logic [10*NUM_LAYERS-1:0]    y_start;
    logic [NUM_LAYERS*G-1:0]     glyph;
    logic [24*NUM_LAYERS-1:0]    layer_color;
    logic [NUM_LAYERS-1:0]       blink;
    logic [23:0]                 rgb;
    logic [NUM_LAYERS-1:0]       layer_hit;

    modport master (
        output pix_en, bright, hcount, vcount, layer_en, x_start, y_start,
               glyph, layer_color, blink,
        input  rgb, layer_hit
    );

    modport slave (
        input  pix_en, bright, hcount, vcount, layer_en, x_start, y_start,
               glyph, layer_color, blink,
        output rgb, layer_hit
    );
endinterface

// File: rtl/glyph_layer_gen.sv
// Two-stage glyph compositor: stage 1 computes per-layer window/col/row, stage 2 selects bits and priority-muxes colour.
// Define GLYPH_BLINK_EN to enable frame-based per-layer blinking.
module glyph_layer_gen #(
    parameter int          GLYPH_W      = 8,
    parameter int          GLYPH_H      = 8,
    parameter int          NUM_LAYERS   = 2,
    parameter int          SCALE_SHIFT  = 0,
    parameter logic [23:0] BG_COLOR     = 24'hf8f9fa,
    parameter int          BLINK_FRAMES = 30
) (
    input logic              clk,
    input logic              reset,
    glyph_layer_gen_if.slave bus
);
    localparam int G  = GLYPH_W * GLYPH_H;
    localparam int WX = GLYPH_W << SCALE_SHIFT;
    localparam int WY = GLYPH_H << SCALE_SHIFT;
    localparam int CW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int RW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
    localparam int GW = (G > 1) ? $clog2(G) : 1;

    logic [NUM_LAYERS-1:0] blank;
    logic [NUM_LAYERS-1:0] win_c;
    logic [NUM_LAYERS-1:0] win_q;
    logic [NUM_LAYERS-1:0] on_c;
    logic [CW-1:0]         col_c [NUM_LAYERS];
    logic [CW-1:0]         col_q [NUM_LAYERS];
    logic [RW-1:0]         row_c [NUM_LAYERS];
    logic [RW-1:0]         row_q [NUM_LAYERS];
    logic                  bright_q;
    logic [23:0]           rgb_c;

`ifdef GLYPH_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic          frame_start;

    assign frame_start = bus.pix_en && (bus.hcount == 10'd0) && (bus.vcount == 10'd0);

    // Stage 1 reads the registered phase, so a coinciding frame start still sees the old phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

    assign blank = bus.blink & {NUM_LAYERS{blink_phase}};
`else
    logic [NUM_LAYERS-1:0] unused_blink;
    assign unused_blink = bus.blink;
    assign blank        = '0;
`endif

    // 11-bit compares keep x_start+WX from wrapping, so windows past 1023 simply clip.
    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_win
        logic [10:0] hc;
        logic [10:0] vc;
        logic [10:0] xs;
        logic [10:0] ys;

        assign hc = {1'b0, bus.hcount};
        assign vc = {1'b0, bus.vcount};
        assign xs = {1'b0, bus.x_start[10*i +: 10]};
        assign ys = {1'b0, bus.y_start[10*i +: 10]};

        assign win_c[i] = (hc >= xs) && (hc < xs + 11'(WX)) &&
                          (vc >= ys) && (vc < ys + 11'(WY));
        assign col_c[i] = CW'((hc - xs) >> SCALE_SHIFT);
        assign row_c[i] = RW'((vc - ys) >> SCALE_SHIFT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q    <= '0;
            bright_q <= 1'b0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                col_q[i] <= '0;
                row_q[i] <= '0;
            end
        end else if (bus.pix_en) begin
            win_q    <= win_c & bus.layer_en & ~blank;
            bright_q <= bus.bright;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                col_q[i] <= win_c[i] ? col_c[i] : '0;
                row_q[i] <= win_c[i] ? row_c[i] : '0;
            end
        end
    end

    // Row 0 sits at the bitmap MSB end and column 0 is the MSB of each row.
    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_bit
        logic [G-1:0]  bitmap;
        logic [GW-1:0] idx;

        assign bitmap  = bus.glyph[G*i +: G];
        assign idx     = GW'(G - 1) - (GW'(row_q[i]) * GW'(GLYPH_W) + GW'(col_q[i]));
        assign on_c[i] = win_q[i] & bitmap[idx];
    end

    always_comb begin
        rgb_c = BG_COLOR;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (on_c[i]) begin
                rgb_c = bus.layer_color[24*i +: 24];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rgb       <= BG_COLOR;
            bus.layer_hit <= '0;
        end else if (bus.pix_en) begin
            if (bright_q) begin
                bus.rgb       <= rgb_c;
                bus.layer_hit <= on_c;
            end else begin
                bus.rgb       <= BG_COLOR;
                bus.layer_hit <= '0;
            end
        end
    end
endmodule

// File: tb/tb_glyph_layer_gen.sv
// Self-checking bench for glyph_layer_gen: vector table, hand-written reset/stall/overlap/blink sequences and
// randomized traffic against a behavioural model; runs a scale-0 and a scale-1 instance side by side.
`timescale 1ns/1ps
module tb_glyph_layer_gen;
    localparam int          NL   = 2;
    localparam int          GW   = 8;
    localparam int          GH   = 8;
    localparam int          G    = GW * GH;
    localparam logic [23:0] BG   = 24'hf8f9fa;
    localparam logic [23:0] RED  = 24'hff0000;
    localparam logic [23:0] GRN  = 24'h00ff00;
    localparam logic [23:0] BLUE = 24'h0000ff;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    int          xs  [NL];
    int          ys  [NL];
    logic [G-1:0] gl [NL];
    logic [23:0] col [NL];

    always #5 clk = ~clk;

    glyph_layer_gen_if #(.GLYPH_W(GW), .GLYPH_H(GH), .NUM_LAYERS(NL)) bus0 ();
    glyph_layer_gen_if #(.GLYPH_W(GW), .GLYPH_H(GH), .NUM_LAYERS(NL)) bus1 ();

    assign bus1.pix_en      = bus0.pix_en;
    assign bus1.bright      = bus0.bright;
    assign bus1.hcount      = bus0.hcount;
    assign bus1.vcount      = bus0.vcount;
    assign bus1.layer_en    = bus0.layer_en;
    assign bus1.x_start     = bus0.x_start;
    assign bus1.y_start     = bus0.y_start;
    assign bus1.glyph       = bus0.glyph;
    assign bus1.layer_color = bus0.layer_color;
    assign bus1.blink       = bus0.blink;

    glyph_layer_gen #(
        .GLYPH_W(GW), .GLYPH_H(GH), .NUM_LAYERS(NL), .SCALE_SHIFT(0),
        .BG_COLOR(BG), .BLINK_FRAMES(2)
    ) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    glyph_layer_gen #(
        .GLYPH_W(GW), .GLYPH_H(GH), .NUM_LAYERS(NL), .SCALE_SHIFT(1),
        .BG_COLOR(BG), .BLINK_FRAMES(30)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    typedef struct {
        int          hc;
        int          vc;
        logic        br;
        logic [1:0]  en;
        logic [23:0] r0;
        logic [1:0]  h0;
        logic [23:0] r1;
        logic [1:0]  h1;
    } vec_t;

    vec_t vecs [15];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pushConfig();
        bus0.x_start     = {10'(xs[1]), 10'(xs[0])};
        bus0.y_start     = {10'(ys[1]), 10'(ys[0])};
        bus0.glyph       = {gl[1], gl[0]};
        bus0.layer_color = {col[1], col[0]};
    endtask

    task automatic drivePixel(input int hc, input int vc, input logic br, input logic [1:0] en);
        bus0.hcount   = 10'(hc);
        bus0.vcount   = 10'(vc);
        bus0.bright   = br;
        bus0.layer_en = en;
    endtask

    task automatic applyStimulus(input int hc, input int vc, input logic br, input logic [1:0] en);
        drivePixel(hc, vc, br, en);
        bus0.pix_en = 1'b1;
        tick();
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [23:0] act_rgb, input logic [1:0] act_hit,
                               input logic [23:0] exp_rgb, input logic [1:0] exp_hit);
        checks++;
        if (act_rgb !== exp_rgb || act_hit !== exp_hit) begin
            failures++;
            $display("[TB] FAIL %s: got rgb=%h hit=%b, expected rgb=%h hit=%b",
                     name, act_rgb, act_hit, exp_rgb, exp_hit);
        end
    endtask

    // Reference: each layer is a (8<<s)x(8<<s) box; a pixel maps to glyph cell (dx/2^s, dy/2^s).
    function automatic void model(input int s, input int hc, input int vc, input logic br, input logic [1:0] en,
                                  output logic [23:0] m_rgb, output logic [1:0] m_hit);
        int span_x;
        int span_y;
        int c;
        int r;
        m_rgb  = BG;
        m_hit  = '0;
        span_x = GW * (1 << s);
        span_y = GH * (1 << s);
        if (!br) return;
        for (int i = NL - 1; i >= 0; i--) begin
            if (en[i] && hc >= xs[i] && hc < xs[i] + span_x && vc >= ys[i] && vc < ys[i] + span_y) begin
                c = (hc - xs[i]) / (1 << s);
                r = (vc - ys[i]) / (1 << s);
                if (gl[i][G - 1 - (r * GW + c)]) begin
                    m_hit[i] = 1'b1;
                    m_rgb    = col[i];
                end
            end
        end
    endfunction

    initial begin
        logic [23:0] s1_rgb0, s1_rgb1, out_rgb0, out_rgb1, m_rgb0, m_rgb1;
        logic [1:0]  s1_hit0, s1_hit1, out_hit0, out_hit1, m_hit0, m_hit1;
        logic        s1_v, out_v, pe, vis;
        int          hc, vc, k;
        logic [1:0]  en;
        logic        br;

        vecs[0]  = '{100,  50, 1'b1, 2'b11, RED,  2'b01, RED,  2'b01};
        vecs[1]  = '{101,  50, 1'b1, 2'b11, BG,   2'b00, RED,  2'b01};
        vecs[2]  = '{107,  50, 1'b1, 2'b11, RED,  2'b01, BG,   2'b00};
        vecs[3]  = '{108,  50, 1'b1, 2'b11, BG,   2'b00, BG,   2'b00};
        vecs[4]  = '{100,  50, 1'b0, 2'b11, BG,   2'b00, BG,   2'b00};
        vecs[5]  = '{101,  51, 1'b1, 2'b11, BG,   2'b00, RED,  2'b01};
        vecs[6]  = '{102,  50, 1'b1, 2'b11, BG,   2'b00, BG,   2'b00};
        vecs[7]  = '{114,  50, 1'b1, 2'b11, BG,   2'b00, RED,  2'b01};
        vecs[8]  = '{116,  50, 1'b1, 2'b11, BG,   2'b00, BG,   2'b00};
        vecs[9]  = '{ 99,  50, 1'b1, 2'b11, BG,   2'b00, BG,   2'b00};
        vecs[10] = '{200, 100, 1'b1, 2'b11, BLUE, 2'b10, BLUE, 2'b10};
        vecs[11] = '{207, 107, 1'b1, 2'b11, BLUE, 2'b10, BLUE, 2'b10};
        vecs[12] = '{208, 107, 1'b1, 2'b11, BG,   2'b00, BLUE, 2'b10};
        vecs[13] = '{100,  50, 1'b1, 2'b10, BG,   2'b00, BG,   2'b00};
        vecs[14] = '{215, 115, 1'b1, 2'b11, BG,   2'b00, BLUE, 2'b10};

        xs[0] = 100; ys[0] = 50;  gl[0] = {8'h81, 56'h0}; col[0] = RED;
        xs[1] = 200; ys[1] = 100; gl[1] = '1;             col[1] = BLUE;
        pushConfig();
        bus0.blink  = 2'b00;
        bus0.pix_en = 1'b1;
        drivePixel(100, 50, 1'b1, 2'b11);
        reset = 1'b1;
        tick();
        tick();
        checkOutput("reset_state_d0", bus0.rgb, bus0.layer_hit, BG, 2'b00);
        checkOutput("reset_state_d1", bus1.rgb, bus1.layer_hit, BG, 2'b00);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].hc, vecs[i].vc, vecs[i].br, vecs[i].en);
            checkOutput($sformatf("vec%0d_d0", i), bus0.rgb, bus0.layer_hit, vecs[i].r0, vecs[i].h0);
            checkOutput($sformatf("vec%0d_d1", i), bus1.rgb, bus1.layer_hit, vecs[i].r1, vecs[i].h1);
        end

        // Mid-line asynchronous reset, then the two-tick refill.
        applyStimulus(100, 50, 1'b1, 2'b11);
        checkOutput("pre_reset", bus0.rgb, bus0.layer_hit, RED, 2'b01);
        #2 reset = 1'b1;
        #1;
        checkOutput("reset_async_d0", bus0.rgb, bus0.layer_hit, BG, 2'b00);
        checkOutput("reset_async_d1", bus1.rgb, bus1.layer_hit, BG, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        tick();
        checkOutput("post_reset_tick1", bus0.rgb, bus0.layer_hit, BG, 2'b00);
        tick();
        checkOutput("post_reset_tick2", bus0.rgb, bus0.layer_hit, RED, 2'b01);

        // Stall with a moving hcount: outputs hold, then resume with two-tick latency.
        bus0.pix_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus0.hcount = 10'(101 + 3 * i);
            tick();
            checkOutput($sformatf("stall_hold%0d_d0", i), bus0.rgb, bus0.layer_hit, RED, 2'b01);
            checkOutput($sformatf("stall_hold%0d_d1", i), bus1.rgb, bus1.layer_hit, RED, 2'b01);
        end
        bus0.hcount = 10'd101;
        bus0.pix_en = 1'b1;
        tick();
        checkOutput("resume_tick1", bus0.rgb, bus0.layer_hit, RED, 2'b01);
        tick();
        checkOutput("resume_tick2", bus0.rgb, bus0.layer_hit, BG, 2'b00);

        // Overlap at (200,100): layer 0 wins the colour, both report a hit.
        xs[0] = 200; ys[0] = 100; gl[0] = '1; col[0] = GRN;
        pushConfig();
        applyStimulus(200, 100, 1'b1, 2'b11);
        checkOutput("overlap_d0", bus0.rgb, bus0.layer_hit, GRN, 2'b11);
        checkOutput("overlap_d1", bus1.rgb, bus1.layer_hit, GRN, 2'b11);
        applyStimulus(200, 100, 1'b1, 2'b10);
        checkOutput("overlap_l0_off", bus0.rgb, bus0.layer_hit, BLUE, 2'b10);

        // Randomized traffic with random pix_en stalls; glyph/colour held constant within a batch.
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < NL; i++) begin
                gl[i]  = {$urandom, $urandom};
                col[i] = 24'($urandom);
            end
            s1_v  = 1'b0;
            out_v = 1'b0;
            s1_rgb0 = BG; s1_rgb1 = BG; out_rgb0 = BG; out_rgb1 = BG;
            s1_hit0 = '0; s1_hit1 = '0; out_hit0 = '0; out_hit1 = '0;
            for (int n = 0; n < 200; n++) begin
                for (int i = 0; i < NL; i++) begin
                    xs[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(1008, 1023) : $urandom_range(0, 1023);
                    ys[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(1008, 1023) : $urandom_range(0, 1023);
                end
                pushConfig();
                k  = $urandom_range(0, NL - 1);
                hc = (xs[k] + 1024 + $urandom_range(0, 20) - 2) % 1024;
                vc = (ys[k] + 1024 + $urandom_range(0, 20) - 2) % 1024;
                en = 2'($urandom);
                br = ($urandom_range(0, 7) != 0);
                pe = ($urandom_range(0, 3) != 0);
                drivePixel(hc, vc, br, en);
                bus0.pix_en = pe;
                model(0, hc, vc, br, en, m_rgb0, m_hit0);
                model(1, hc, vc, br, en, m_rgb1, m_hit1);
                @(posedge clk);
                if (pe) begin
                    out_rgb0 = s1_rgb0; out_hit0 = s1_hit0;
                    out_rgb1 = s1_rgb1; out_hit1 = s1_hit1;
                    out_v    = s1_v;
                    s1_rgb0  = m_rgb0;  s1_hit0  = m_hit0;
                    s1_rgb1  = m_rgb1;  s1_hit1  = m_hit1;
                    s1_v     = 1'b1;
                end
                @(negedge clk);
                if (out_v) begin
                    checkOutput($sformatf("rand_b%0d_n%0d_d0", b, n), bus0.rgb, bus0.layer_hit, out_rgb0, out_hit0);
                    checkOutput($sformatf("rand_b%0d_n%0d_d1", b, n), bus1.rgb, bus1.layer_hit, out_rgb1, out_hit1);
                end
            end
        end

        // Blinking on layer 0 with two frames per half-period; frame 0 is the one in progress at reset release.
        xs[0] = 200; ys[0] = 100; gl[0] = '1; col[0] = GRN;
        xs[1] = 600; ys[1] = 400;
        pushConfig();
        bus0.blink  = 2'b01;
        bus0.pix_en = 1'b1;
        drivePixel(300, 300, 1'b1, 2'b01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int f = 0; f < 5; f++) begin
            if (f > 0) begin
                drivePixel(0, 0, 1'b1, 2'b01);
                tick();
            end
            applyStimulus(200, 100, 1'b1, 2'b01);
`ifdef GLYPH_BLINK_EN
            vis = ((f / 2) % 2) == 0;
`else
            vis = 1'b1;
`endif
            checkOutput($sformatf("blink_frame%0d", f), bus0.rgb, bus0.layer_hit,
                        vis ? GRN : BG, vis ? 2'b01 : 2'b00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
